// File: rtl/tmvp_tile_scheduler_if.sv
// Scheduler <-> TMVP core, result RAM and AXI-Stream output bundle.
// master = scheduler side, slave = core/RAM/stream-sink side.
interface tmvp_tile_scheduler_if #(
  parameter int N         = 512,
  parameter int SIZE_TMVP = 32,
  parameter int OUT_WIDTH = 17
);
  localparam int NB   = N / SIZE_TMVP;
  localparam int NB_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int A_W  = $clog2(N);

  logic                 blk_start;
  logic [NB_W-1:0]      blk_row;
  logic [NB_W-1:0]      blk_col;
  logic                 blk_first;
  logic                 blk_done;
  logic                 acc_rd_en;
  logic [A_W-1:0]       acc_rd_addr;
  logic [OUT_WIDTH-1:0] acc_rd_data;
  logic [OUT_WIDTH-1:0] m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;

  modport master (
    output blk_start, blk_row, blk_col, blk_first,
    input  blk_done,
    output acc_rd_en, acc_rd_addr,
    input  acc_rd_data,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  blk_start, blk_row, blk_col, blk_first,
    output blk_done,
    input  acc_rd_en, acc_rd_addr,
    output acc_rd_data,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/tmvp_tile_scheduler.sv
// TMVP tile sequencer: NB*NB row-major tiles, one outstanding, then streams REAL_N results with full tready backpressure.
// Optional TMVP_SCHED_CYCLE_CNT_EN adds a saturating 32-bit busy-cycle counter output.
module tmvp_tile_scheduler #(
  parameter int N         = 512,
  parameter int SIZE_TMVP = 32,
  parameter int REAL_N    = 509,
  parameter int OUT_WIDTH = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
`ifdef TMVP_SCHED_CYCLE_CNT_EN
  output logic [31:0] cycle_count,
`endif
  tmvp_tile_scheduler_if.master sched
);
  localparam int NB   = N / SIZE_TMVP;
  localparam int NB_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int A_W  = $clog2(N);
  localparam logic [NB_W-1:0] LAST_IDX  = NB_W'(NB - 1);
  localparam logic [A_W:0]    REAL_N_C  = (A_W + 1)'(REAL_N);
  localparam logic [A_W-1:0]  LAST_ADDR = A_W'(REAL_N - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_FINISH} state_t;
  state_t state;

  logic                 blk_start_r;
  logic                 blk_first_r;
  logic [NB_W-1:0]      row;
  logic [NB_W-1:0]      col;
  logic                 rd_en;
  logic [A_W-1:0]       rd_addr;
  logic [A_W:0]         rd_next;
  logic                 inflight;
  logic                 inflight_last;
  logic [OUT_WIDTH-1:0] fifo_dat [2];
  logic                 fifo_last [2];
  logic [1:0]           fifo_cnt;
  logic                 wr_ptr;
  logic                 rd_ptr;

  logic                 fifo_vld;
  logic                 head_vld;
  logic [OUT_WIDTH-1:0] head_dat;
  logic                 head_last;
  logic                 beat;
  logic                 push;
  logic                 pop;
  logic [1:0]           cnt_nxt;
  logic                 rd_room;
  logic                 more_reads;

  // An empty FIFO forwards the returning RAM word straight to the stream, so
  // the first beat is visible the cycle the data arrives; it is captured only
  // if the sink does not take it that cycle.
  always_comb begin
    fifo_vld   = (fifo_cnt != 2'd0);
    head_vld   = fifo_vld | inflight;
    head_dat   = fifo_vld ? fifo_dat[rd_ptr] : (inflight ? sched.acc_rd_data : '0);
    head_last  = fifo_vld ? fifo_last[rd_ptr] : (inflight & inflight_last);
    beat       = head_vld & sched.m_axis_tready;
    push       = inflight & ~(~fifo_vld & beat);
    pop        = beat & fifo_vld;
    cnt_nxt    = fifo_cnt + {1'b0, push} - {1'b0, pop};
    rd_room    = ({1'b0, cnt_nxt} + {2'b00, rd_en}) < 3'd2;
    more_reads = rd_next < REAL_N_C;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dat[wr_ptr]  <= sched.acc_rd_data;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_cnt      <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      fifo_cnt      <= cnt_nxt;
      inflight      <= rd_en;
      inflight_last <= rd_en && (rd_addr == LAST_ADDR);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // The launch pulse is registered on entry to WAIT; ISSUE is the turnaround
  // cycle between tiles, skipped on a fresh start to keep start->launch at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      blk_start_r <= 1'b0;
      blk_first_r <= 1'b0;
      row         <= '0;
      col         <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      rd_next     <= '0;
    end else begin
      blk_start_r <= 1'b0;
      blk_first_r <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            row         <= '0;
            col         <= '0;
            busy        <= 1'b1;
            blk_start_r <= 1'b1;
            blk_first_r <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_ISSUE: begin
          blk_start_r <= 1'b1;
          blk_first_r <= (col == '0);
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (sched.blk_done && !blk_start_r) begin
            if (col == LAST_IDX) begin
              col <= '0;
              row <= row + 1'b1;
              if (row == LAST_IDX) begin
                rd_en   <= 1'b1;
                rd_addr <= '0;
                rd_next <= (A_W + 1)'(1);
                state   <= S_DRAIN;
              end else begin
                state <= S_ISSUE;
              end
            end else begin
              col   <= col + 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        S_DRAIN: begin
          if (rd_room && more_reads) begin
            rd_en   <= 1'b1;
            rd_addr <= rd_next[A_W-1:0];
            rd_next <= rd_next + 1'b1;
          end
          if (beat && head_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

`ifdef TMVP_SCHED_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      cycle_count <= '0;
    else if (state == S_IDLE && start)
      cycle_count <= '0;
    else if (busy && cycle_count != '1)
      cycle_count <= cycle_count + 32'd1;
  end
`endif

  assign sched.blk_start     = blk_start_r;
  assign sched.blk_row       = row;
  assign sched.blk_col       = col;
  assign sched.blk_first     = blk_first_r;
  assign sched.acc_rd_en     = rd_en;
  assign sched.acc_rd_addr   = rd_addr;
  assign sched.m_axis_tdata  = head_dat;
  assign sched.m_axis_tvalid = head_vld;
  assign sched.m_axis_tlast  = head_last;
endmodule

// File: tb/tb_tmvp_tile_scheduler.sv
// Directed bench for tmvp_tile_scheduler: 3-cycle core model, data=addr RAM model, optional random tready.
module tb_tmvp_tile_scheduler;
  localparam int N = 512, SZ = 32, REAL_N = 509, OW = 17, NB = 16, A_W = 9;
  localparam int LIM = 6000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done;
`ifdef TMVP_SCHED_CYCLE_CNT_EN
  logic [31:0] cycle_count;
`endif

  tmvp_tile_scheduler_if #(.N(N), .SIZE_TMVP(SZ), .OUT_WIDTH(OW)) bus ();

  tmvp_tile_scheduler #(.N(N), .SIZE_TMVP(SZ), .REAL_N(REAL_N), .OUT_WIDTH(OW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
`ifdef TMVP_SCHED_CYCLE_CNT_EN
    .cycle_count(cycle_count),
`endif
    .sched(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int rdy_mode = 0;
  int n_tiles, order_err, first_err, lat_err, beats, data_err, last_err, gap_err;
  int stall_err, addr_err, n_done, busy_cycles;
  time last_bd_t, first_bs_t, first_tv_t, last_beat_t, done_t;
  logic prev_stall = 1'b0;
  logic [OW-1:0] prev_dat = '0;
  logic prev_last = 1'b0;

  // Core model: blk_done three cycles after each blk_start.
  initial begin
    int cd;
    cd = 0;
    bus.blk_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.blk_done = 1'b0;
      if (reset) cd = 0;
      else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.blk_done = 1'b1;
            last_bd_t = $time;
          end
        end
        if (bus.blk_start) cd = 3;
      end
    end
  end

  // Result RAM model: data = address, one cycle after the read.
  initial begin
    logic en;
    logic [A_W-1:0] a;
    bus.acc_rd_data = '0;
    forever begin
      @(negedge clk);
      en = bus.acc_rd_en;
      a  = bus.acc_rd_addr;
      if (en && int'(a) >= REAL_N) addr_err++;
      @(posedge clk);
      #1;
      bus.acc_rd_data = en ? OW'(a) : 17'h15555;
    end
  end

  initial begin
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_axis_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Observation collector; the test tasks judge its totals.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) prev_stall = 1'b0;
      else begin
        if (busy) busy_cycles++;
        if (bus.blk_start) begin
          if (int'(bus.blk_row) != n_tiles / NB || int'(bus.blk_col) != n_tiles % NB) order_err++;
          if (bus.blk_first !== (n_tiles % NB == 0)) first_err++;
          if (n_tiles > 0 && ($time - last_bd_t) != 20) lat_err++;
          if (n_tiles == 0) first_bs_t = $time;
          n_tiles++;
        end else if (bus.blk_first) first_err++;
        if (bus.m_axis_tvalid && first_tv_t == 0) first_tv_t = $time;
        if (prev_stall && (!bus.m_axis_tvalid || bus.m_axis_tdata !== prev_dat ||
                           bus.m_axis_tlast !== prev_last)) stall_err++;
        if (beats > 0 && beats < REAL_N && bus.m_axis_tready && !bus.m_axis_tvalid) gap_err++;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          if (bus.m_axis_tdata !== OW'(beats)) data_err++;
          if (bus.m_axis_tlast !== (beats == REAL_N - 1)) last_err++;
          if (beats == REAL_N - 1) last_beat_t = $time;
          beats++;
        end
        prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_dat   = bus.m_axis_tdata;
        prev_last  = bus.m_axis_tlast;
        if (done) begin
          n_done++;
          done_t = $time;
        end
      end
    end
  end

  task automatic clear_mon();
    n_tiles = 0; order_err = 0; first_err = 0; lat_err = 0; beats = 0; data_err = 0;
    last_err = 0; gap_err = 0; stall_err = 0; addr_err = 0; n_done = 0; busy_cycles = 0;
    last_bd_t = 0; first_bs_t = 0; first_tv_t = 0; last_beat_t = 0; done_t = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // what: 0 = tiles launched, 1 = beats transferred, 2 = done pulses
  task automatic wait_for(input int what, input int val, output bit timed_out);
    int k = 0;
    while (((what == 0) ? n_tiles : (what == 1) ? beats : n_done) < val && k < LIM) begin
      @(posedge clk);
      k++;
    end
    timed_out = (k >= LIM);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    logic [6:0] ctl;
    logic [OW+2*4+A_W-1:0] bus_v;
    ctl   = {busy, done, bus.blk_start, bus.blk_first, bus.acc_rd_en, bus.m_axis_tvalid, bus.m_axis_tlast};
    bus_v = {bus.m_axis_tdata, bus.blk_row, bus.blk_col, bus.acc_rd_addr};
    checks++;
    if (ctl !== 7'd0) begin
      failures++;
      $display("FAIL %s_ctl: got %b want 0000000", tag, ctl);
    end
    checks++;
    if (bus_v !== '0) begin
      failures++;
      $display("FAIL %s_bus: got %h want 0", tag, bus_v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset");
  endtask

  task automatic test_full_run();
    bit to;
    rdy_mode = 0;
    clear_mon();
    pulse_start();
    @(negedge clk);
    checks++;
    if ({busy, bus.blk_start, bus.blk_first, bus.blk_row, bus.blk_col} !== {3'b111, 8'd0}) begin
      failures++;
      $display("FAIL start_latency: got busy=%b blk_start=%b first=%b row=%0d col=%0d want 1 1 1 0 0",
               busy, bus.blk_start, bus.blk_first, bus.blk_row, bus.blk_col);
    end
    wait_for(2, 1, to);
    checks++;
    if (to) begin failures++; $display("FAIL run_timeout: no done within %0d cycles", LIM); end
    checks++;
    if (n_tiles != 256) begin failures++; $display("FAIL tile_count: got %0d want 256", n_tiles); end
    checks++;
    if (order_err != 0) begin failures++; $display("FAIL tile_order: %0d bad tiles want 0", order_err); end
    checks++;
    if (first_err != 0) begin failures++; $display("FAIL blk_first: %0d errors want 0", first_err); end
    checks++;
    if (lat_err != 0) begin failures++; $display("FAIL done_to_start: %0d gaps not 2 cycles", lat_err); end
    checks++;
    if (beats != REAL_N || data_err != 0 || last_err != 0) begin
      failures++;
      $display("FAIL stream: beats=%0d data_err=%0d last_err=%0d want %0d 0 0", beats, data_err, last_err, REAL_N);
    end
    checks++;
    if (gap_err != 0) begin failures++; $display("FAIL tvalid_gaps: got %0d want 0", gap_err); end
    checks++;
    if (addr_err != 0) begin failures++; $display("FAIL rd_addr_range: %0d reads >= %0d", addr_err, REAL_N); end
    checks++;
    if (first_tv_t - last_bd_t != 20) begin
      failures++;
      $display("FAIL first_tvalid: %0d ns after final blk_done want 20", first_tv_t - last_bd_t);
    end
    checks++;
    if (last_beat_t - last_bd_t != (REAL_N + 1) * 10) begin
      failures++;
      $display("FAIL last_beat: %0d ns after final blk_done want %0d", last_beat_t - last_bd_t, (REAL_N + 1) * 10);
    end
    checks++;
    if (done_t - last_beat_t != 10) begin
      failures++;
      $display("FAIL done_latency: %0d ns after last beat want 10", done_t - last_beat_t);
    end
    checks++;
    if (busy_cycles * 10 != done_t - first_bs_t || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_span: busy_cycles=%0d span=%0d busy_now=%b want span/10 and 0",
               busy_cycles, (done_t - first_bs_t) / 10, busy);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    rdy_mode = 1;
    clear_mon();
    pulse_start();
    wait_for(2, 1, to);
    checks++;
    if (to) begin failures++; $display("FAIL bp_timeout: no done within %0d cycles", LIM); end
    checks++;
    if (beats != REAL_N || data_err != 0 || last_err != 0) begin
      failures++;
      $display("FAIL bp_stream: beats=%0d data_err=%0d last_err=%0d want %0d 0 0", beats, data_err, last_err, REAL_N);
    end
    checks++;
    if (stall_err != 0) begin failures++; $display("FAIL bp_stall_stable: %0d unstable stalls want 0", stall_err); end
    checks++;
    if (addr_err != 0 || n_tiles != 256) begin
      failures++;
      $display("FAIL bp_counts: addr_err=%0d tiles=%0d want 0 256", addr_err, n_tiles);
    end
    rdy_mode = 0;
  endtask

  task automatic test_start_ignored();
    bit to1, to2, to3;
    rdy_mode = 1;
    clear_mon();
    pulse_start();
    wait_for(0, 41, to1);
    pulse_start();
    wait_for(1, 100, to2);
    pulse_start();
    wait_for(2, 1, to3);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (to1 || to2 || to3) begin failures++; $display("FAIL ign_timeout: %b%b%b want 000", to1, to2, to3); end
    checks++;
    if (n_tiles != 256 || beats != REAL_N || n_done != 1) begin
      failures++;
      $display("FAIL ign_counts: tiles=%0d beats=%0d done=%0d want 256 %0d 1", n_tiles, beats, n_done, REAL_N);
    end
    checks++;
    if (order_err != 0 || data_err != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ign_order: order_err=%0d data_err=%0d busy=%b want 0 0 0", order_err, data_err, busy);
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_midrun();
    bit to1, to2, to3;
    rdy_mode = 0;
    clear_mon();
    pulse_start();
    wait_for(0, 101, to1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_outputs_zero("rst_wait");
    repeat (10) @(posedge clk);
    #1;
    clear_mon();
    pulse_start();
    wait_for(1, 200, to2);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_outputs_zero("rst_drain");
    repeat (10) @(posedge clk);
    #1;
    clear_mon();
    pulse_start();
    wait_for(2, 1, to3);
    checks++;
    if (to1 || to2 || to3) begin failures++; $display("FAIL rst_timeout: %b%b%b want 000", to1, to2, to3); end
    checks++;
    if (n_tiles != 256 || order_err != 0 || beats != REAL_N || data_err != 0 || last_err != 0) begin
      failures++;
      $display("FAIL rst_restart: tiles=%0d order_err=%0d beats=%0d data_err=%0d last_err=%0d",
               n_tiles, order_err, beats, data_err, last_err);
    end
  endtask

`ifdef TMVP_SCHED_CYCLE_CNT_EN
  task automatic test_cycle_count();
    bit to;
    logic [31:0] snap;
    rdy_mode = 0;
    clear_mon();
    pulse_start();
    wait_for(2, 1, to);
    @(negedge clk);
    checks++;
    if (to || cycle_count !== 32'(busy_cycles)) begin
      failures++;
      $display("FAIL cycle_count: got %0d want %0d (timeout=%b)", cycle_count, busy_cycles, to);
    end
    snap = 32'(busy_cycles);
    repeat (5) @(negedge clk);
    checks++;
    if (cycle_count !== snap) begin
      failures++;
      $display("FAIL cycle_count_hold: got %0d want %0d", cycle_count, snap);
    end
  endtask
`endif

  initial begin
    clear_mon();
    test_reset();
    test_full_run();
    test_backpressure();
    test_start_ignored();
    test_reset_midrun();
`ifdef TMVP_SCHED_CYCLE_CNT_EN
    test_cycle_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
